// File: rtl/scan_cmd_engine.sv
// scan_cmd_engine: decodes single-byte UART commands and drives a DUT test
// interface (scan load/unload, N-cycle execute, PI set, PO readback).
// Optional feature macro: SCAN_RECIRC_EN. When it is defined, a 'g' readback
// feeds the chain's scan-out back into scan-in so the chain contents survive.
module scan_cmd_engine #(
    parameter int CHAIN_LEN = 1919,
    parameter int PI_W      = 8,
    parameter int PO_W      = 8,
    parameter int CLK_DIV   = 1,
    parameter int NCLK_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_ready,
    output logic            dut_clk,
    output logic            dut_rst,
    output logic            dut_se,
    output logic            dut_tm,
    output logic            dut_si,
    input  logic            dut_so,
    output logic [PI_W-1:0] dut_pi,
    input  logic [PO_W-1:0] dut_po,
    output logic            busy,
    output logic            error
);

    // Byte counts of the multi-byte fields (little-endian, LSB first)
    localparam int CB    = (CHAIN_LEN + 7) / 8;
    localparam int IB    = (PI_W + 7) / 8;
    localparam int OB    = (PO_W + 7) / 8;
    localparam int NB    = (NCLK_W + 7) / 8;
    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int BC_W  = $clog2(CB + IB + OB + NB + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Shift count of the final 's' byte (a partial byte when CHAIN_LEN%8 != 0)
    localparam logic [3:0] LAST_BITS = ((CHAIN_LEN % 8) == 0) ? 4'd8 : 4'(CHAIN_LEN % 8);
    localparam logic [BIT_W-1:0] CHAIN_END = BIT_W'(CHAIN_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RSTDUT  = 3'd1;
    localparam logic [2:0] S_ARG     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_TX_REQ  = 3'd5;
    localparam logic [2:0] S_TX_BUSY = 3'd6;
    localparam logic [2:0] S_TX_DONE = 3'd7;

    localparam logic [7:0] CMD_R   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_S   = 8'h73;  // 's'
    localparam logic [7:0] CMD_G   = 8'h67;  // 'g'
    localparam logic [7:0] CMD_O   = 8'h6F;  // 'o'
    localparam logic [7:0] CMD_E   = 8'h65;  // 'e'
    localparam logic [7:0] CMD_I   = 8'h69;  // 'i'
    localparam logic [7:0] CMD_P   = 8'h70;  // 'p'
    localparam logic [7:0] REPLY_K = 8'h4B;  // 'K'
    localparam logic [7:0] REPLY_Q = 8'h3F;  // '?'

    logic [2:0]        state_reg;
    logic [7:0]        cmd_reg;
    logic [BC_W-1:0]   arg_cnt_reg;
    logic [IB*8-1:0]   pi_acc_reg;
    logic [NB*8-1:0]   n_acc_reg;
    logic [NCLK_W-1:0] run_n_reg;
    logic [NCLK_W-1:0] cyc_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [3:0]        bit_n_reg;
    logic [7:0]        sh_byte_reg;
    logic [7:0]        rd_byte_reg;
    logic [OB*8-1:0]   po_buf_reg;
    logic [7:0]        tx_byte_reg;
    logic [DIV_W-1:0]  div_cnt_reg;

    logic [7:0]        tx_data_reg;
    logic              tx_start_reg;
    logic              dut_clk_reg;
    logic              dut_rst_reg;
    logic              dut_se_reg;
    logic              dut_tm_reg;
    logic              dut_si_reg;
    logic [PI_W-1:0]   dut_pi_reg;
    logic              error_reg;

    logic [IB*8-1:0]   pi_next;
    logic [NB*8-1:0]   n_next;
    logic [OB*8-1:0]   po_ext;
    logic [BC_W-1:0]   arg_total;
    logic              arg_last;
    logic              clk_active;
    logic              div_term;
    logic              dut_rise;
    logic              dut_fall;
    logic              recirc_bit;

    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;
    assign dut_clk  = dut_clk_reg;
    assign dut_rst  = dut_rst_reg;
    assign dut_se   = dut_se_reg;
    assign dut_tm   = dut_tm_reg;
    assign dut_si   = dut_si_reg;
    assign dut_pi   = dut_pi_reg;
    assign error    = error_reg;
    assign busy     = (state_reg != S_IDLE);

    // Argument accumulators: the incoming byte lands in the slot selected by
    // the byte counter, so the full word is available on the last byte's edge
    genvar gi;
    generate
        for (gi = 0; gi < IB; gi++) begin : g_pi_slot
            assign pi_next[gi*8 +: 8] = (arg_cnt_reg == BC_W'(gi)) ? rx_data
                                                                   : pi_acc_reg[gi*8 +: 8];
        end
        for (gi = 0; gi < NB; gi++) begin : g_n_slot
            assign n_next[gi*8 +: 8] = (arg_cnt_reg == BC_W'(gi)) ? rx_data
                                                                  : n_acc_reg[gi*8 +: 8];
        end
        // Primary outputs zero-padded to whole bytes for transmission
        for (gi = 0; gi < OB*8; gi++) begin : g_po_bit
            if (gi < PO_W) begin : g_bit
                assign po_ext[gi] = dut_po[gi];
            end else begin : g_pad
                assign po_ext[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef SCAN_RECIRC_EN
    // The so bit presented while dut_clk is low is exactly the bit sampled at
    // the next rise; feeding it back on si rewrites the chain unchanged.
    assign recirc_bit = dut_so;
`else
    assign recirc_bit = 1'b0;
`endif

    // Number of argument bytes expected by the command being collected
    always_comb begin
        arg_total = BC_W'(IB);
        if (cmd_reg == CMD_S) begin
            arg_total = BC_W'(CB);
        end else if (cmd_reg == CMD_O) begin
            arg_total = BC_W'(NB);
        end
    end

    assign arg_last   = (arg_cnt_reg == (arg_total - BC_W'(1)));
    assign clk_active = (state_reg == S_RSTDUT) || (state_reg == S_SHIFT) || (state_reg == S_RUN);
    assign div_term   = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign dut_rise   = clk_active && !dut_clk_reg && div_term;
    assign dut_fall   = clk_active &&  dut_clk_reg && div_term;

    // DUT clock generator: CLK_DIV cycles low, CLK_DIV high, parked low when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            dut_clk_reg <= 1'b0;
        end else if (!clk_active) begin
            div_cnt_reg <= '0;
            dut_clk_reg <= 1'b0;
        end else if (div_term) begin
            div_cnt_reg <= '0;
            dut_clk_reg <= ~dut_clk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // Command FSM: decode, argument collection, shift/run sequencing and TX handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cmd_reg      <= '0;
            arg_cnt_reg  <= '0;
            pi_acc_reg   <= '0;
            n_acc_reg    <= '0;
            run_n_reg    <= '0;
            cyc_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            bit_n_reg    <= '0;
            sh_byte_reg  <= '0;
            rd_byte_reg  <= '0;
            po_buf_reg   <= '0;
            tx_byte_reg  <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            dut_rst_reg  <= 1'b1;
            dut_se_reg   <= 1'b1;
            dut_tm_reg   <= 1'b1;
            dut_si_reg   <= 1'b0;
            dut_pi_reg   <= '0;
            error_reg    <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (rx_valid) begin
                        cmd_reg     <= rx_data;
                        arg_cnt_reg <= '0;
                        cyc_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        rd_byte_reg <= '0;
                        pi_acc_reg  <= '0;
                        n_acc_reg   <= '0;
                        error_reg   <= 1'b0;
                        case (rx_data)
                            CMD_R: begin
                                dut_rst_reg <= 1'b1;
                                dut_se_reg  <= 1'b1;
                                dut_tm_reg  <= 1'b1;
                                state_reg   <= S_RSTDUT;
                            end
                            CMD_S, CMD_O, CMD_E: begin
                                state_reg <= S_ARG;
                            end
                            CMD_G: begin
                                dut_si_reg <= recirc_bit;
                                state_reg  <= S_SHIFT;
                            end
                            CMD_I: begin
                                tx_byte_reg <= po_ext[7:0];
                                po_buf_reg  <= po_ext >> 8;
                                arg_cnt_reg <= BC_W'(1);
                                state_reg   <= S_TX_REQ;
                            end
                            CMD_P: begin
                                tx_byte_reg <= REPLY_K;
                                state_reg   <= S_TX_REQ;
                            end
                            default: begin
                                error_reg   <= 1'b1;
                                tx_byte_reg <= REPLY_Q;
                                state_reg   <= S_TX_REQ;
                            end
                        endcase
                    end
                end

                S_RSTDUT: begin
                    // Hold DUT reset for two full DUT clock cycles
                    if (dut_fall) begin
                        if (cyc_cnt_reg == NCLK_W'(1)) begin
                            dut_rst_reg <= 1'b0;
                            tx_byte_reg <= REPLY_K;
                            state_reg   <= S_TX_REQ;
                        end else begin
                            cyc_cnt_reg <= cyc_cnt_reg + NCLK_W'(1);
                        end
                    end
                end

                S_ARG: begin
                    if (rx_valid) begin
                        arg_cnt_reg <= arg_cnt_reg + BC_W'(1);
                        case (cmd_reg)
                            CMD_S: begin
                                sh_byte_reg <= rx_data;
                                dut_si_reg  <= rx_data[0];
                                bit_idx_reg <= '0;
                                bit_n_reg   <= arg_last ? LAST_BITS : 4'd8;
                                state_reg   <= S_SHIFT;
                            end
                            CMD_O: begin
                                n_acc_reg <= n_next;
                                if (arg_last) begin
                                    run_n_reg   <= n_next[NCLK_W-1:0];
                                    cyc_cnt_reg <= '0;
                                    if (n_next[NCLK_W-1:0] == '0) begin
                                        tx_byte_reg <= REPLY_K;
                                        state_reg   <= S_TX_REQ;
                                    end else begin
                                        dut_se_reg  <= 1'b0;
                                        dut_tm_reg  <= 1'b0;
                                        dut_rst_reg <= 1'b0;
                                        state_reg   <= S_RUN;
                                    end
                                end
                            end
                            default: begin
                                pi_acc_reg <= pi_next;
                                if (arg_last) begin
                                    dut_pi_reg  <= pi_next[PI_W-1:0];
                                    tx_byte_reg <= REPLY_K;
                                    state_reg   <= S_TX_REQ;
                                end
                            end
                        endcase
                    end
                end

                S_SHIFT: begin
                    if (cmd_reg == CMD_G) begin
                        // Readback: sample on the rise, account the cycle on the fall
                        if (dut_rise) begin
                            rd_byte_reg[bit_idx_reg] <= dut_so;
                        end
                        if (dut_fall) begin
                            dut_si_reg  <= recirc_bit;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            if (bit_cnt_reg != CHAIN_END) begin
                                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            end
                            if ((bit_idx_reg == 3'd7) || (bit_cnt_reg == CHAIN_END - BIT_W'(1))) begin
                                tx_byte_reg <= rd_byte_reg;
                                state_reg   <= S_TX_REQ;
                            end
                        end
                    end else begin
                        // Load: next si bit is presented while dut_clk is low
                        if (dut_fall) begin
                            if ({1'b0, bit_idx_reg} == (bit_n_reg - 4'd1)) begin
                                if (arg_cnt_reg == BC_W'(CB)) begin
                                    tx_byte_reg <= REPLY_K;
                                    state_reg   <= S_TX_REQ;
                                end else begin
                                    state_reg <= S_ARG;
                                end
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                                dut_si_reg  <= sh_byte_reg[bit_idx_reg + 3'd1];
                            end
                        end
                    end
                end

                S_RUN: begin
                    // Functional execution for run_n DUT cycles
                    if (dut_fall) begin
                        if (cyc_cnt_reg == (run_n_reg - NCLK_W'(1))) begin
                            dut_se_reg  <= 1'b1;
                            dut_tm_reg  <= 1'b1;
                            tx_byte_reg <= REPLY_K;
                            state_reg   <= S_TX_REQ;
                        end else if (cyc_cnt_reg != {NCLK_W{1'b1}}) begin
                            cyc_cnt_reg <= cyc_cnt_reg + NCLK_W'(1);
                        end
                    end
                end

                S_TX_REQ: begin
                    if (tx_ready) begin
                        tx_data_reg  <= tx_byte_reg;
                        tx_start_reg <= 1'b1;
                        state_reg    <= S_TX_BUSY;
                    end
                end

                S_TX_BUSY: begin
                    if (!tx_ready) begin
                        state_reg <= S_TX_DONE;
                    end
                end

                default: begin
                    // S_TX_DONE: continue a multi-byte reply or return to idle
                    if (tx_ready) begin
                        if ((cmd_reg == CMD_G) && (bit_cnt_reg != CHAIN_END)) begin
                            rd_byte_reg <= '0;
                            state_reg   <= S_SHIFT;
                        end else if ((cmd_reg == CMD_I) && (arg_cnt_reg != BC_W'(OB))) begin
                            tx_byte_reg <= po_buf_reg[7:0];
                            po_buf_reg  <= po_buf_reg >> 8;
                            arg_cnt_reg <= arg_cnt_reg + BC_W'(1);
                            state_reg   <= S_TX_REQ;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_cmd_engine.sv
// tb_scan_cmd_engine: directed checks of scan_cmd_engine with a 12-bit chain
// model, a UART transmitter responder and DUT clock edge counters.
module tb_scan_cmd_engine;

    localparam int CHAIN_LEN = 12;
    localparam int PI_W      = 12;
    localparam int PO_W      = 12;
    localparam int CLK_DIV   = 2;
    localparam int NCLK_W    = 16;

    localparam logic [7:0] C_R = 8'h72, C_S = 8'h73, C_G = 8'h67, C_O = 8'h6F;
    localparam logic [7:0] C_E = 8'h65, C_I = 8'h69, C_P = 8'h70, C_X = 8'h78;
    localparam logic [7:0] R_K = 8'h4B, R_Q = 8'h3F;

    // {pad, tx_start, tx_data, dut_clk, dut_rst, dut_se, dut_tm, dut_si, dut_pi, busy, error}
    localparam logic [31:0] RST_VEC = {4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_ready = 1'b1;
    logic            dut_clk, dut_rst, dut_se, dut_tm, dut_si, dut_so;
    logic [PI_W-1:0] dut_pi;
    logic [PO_W-1:0] dut_po = '0;
    logic            busy, error;

    int vectors = 0;
    int miscompares = 0;
    int rise_cnt = 0;
    int run_rise_cnt = 0;
    int r0, q0;
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [7:0] tx_q[$];

    scan_cmd_engine #(
        .CHAIN_LEN(CHAIN_LEN), .PI_W(PI_W), .PO_W(PO_W), .CLK_DIV(CLK_DIV), .NCLK_W(NCLK_W)
    ) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .dut_clk(dut_clk), .dut_rst(dut_rst), .dut_se(dut_se), .dut_tm(dut_tm),
        .dut_si(dut_si), .dut_so(dut_so), .dut_pi(dut_pi), .dut_po(dut_po),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Scan chain model: si enters at bit 0, so leaves from the top bit
    assign dut_so = chain[CHAIN_LEN-1];
    always @(posedge dut_clk) begin
        chain    <= {chain[CHAIN_LEN-2:0], dut_si};
        rise_cnt <= rise_cnt + 1;
        if (!dut_se && !dut_tm) run_rise_cnt <= run_rise_cnt + 1;
    end

    // UART transmitter model: accepts a byte, stays busy for 3 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                tx_q.push_back(tx_data);
                tx_ready = 1'b0;
                repeat (3) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] out_vec();
        return {4'd0, tx_start, tx_data, dut_clk, dut_rst, dut_se, dut_tm, dut_si, dut_pi, busy, error};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vector %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        if (tx_q.size() > 0) got = {24'd0, tx_q.pop_front()};
        else got = 32'hFFFF_FFFF;
        check(tag, got, {24'd0, exp});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset values", out_vec(), RST_VEC);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ping
        send(C_P, 0); wait_idle("ping");
        expect_tx("ping reply", R_K);
        check("ping error", {31'd0, error}, 32'd0);

        // Unknown command sets error, next valid command clears it
        send(C_X, 0); wait_idle("bad");
        expect_tx("bad reply", R_Q);
        check("bad error set", {31'd0, error}, 32'd1);
        send(C_P, 0); wait_idle("ping2");
        expect_tx("ping2 reply", R_K);
        check("error cleared", {31'd0, error}, 32'd0);

        // DUT reset pulse: two DUT cycles, then released
        r0 = rise_cnt;
        send(C_R, 0); wait_idle("rstdut");
        expect_tx("rstdut reply", R_K);
        check("rstdut rises", rise_cnt - r0, 32'd2);
        check("rstdut released", {31'd0, dut_rst}, 32'd0);

        // Primary inputs update atomically after the last byte
        send(C_E, 3);
        send(8'h34, 3);
        check("pi before last", {20'd0, dut_pi}, 32'h000);
        send(8'h12, 0);
        check("pi after last", {20'd0, dut_pi}, 32'h234);
        wait_idle("set pi");
        expect_tx("set pi reply", R_K);

        // Primary output readback, padded byte sent as zeros
        dut_po = 12'hABC;
        send(C_I, 0); wait_idle("get po");
        expect_tx("po byte0", 8'hBC);
        expect_tx("po byte1", 8'h0A);

        // Execute 5 cycles; a byte arriving mid-run is dropped
        r0 = rise_cnt; q0 = run_rise_cnt;
        send(C_O, 3); send(8'h05, 3); send(8'h00, 2);
        send(C_P, 0);
        wait_idle("run5");
        check("run5 rises", rise_cnt - r0, 32'd5);
        check("run5 test rises", run_rise_cnt - q0, 32'd5);
        expect_tx("run5 reply", R_K);
        check("run5 extra dropped", tx_q.size(), 32'd0);
        check("run5 se tm restored", {30'd0, dut_se, dut_tm}, 32'd3);

        // Execute zero cycles
        r0 = rise_cnt;
        send(C_O, 3); send(8'h00, 3); send(8'h00, 0);
        wait_idle("run0");
        check("run0 rises", rise_cnt - r0, 32'd0);
        expect_tx("run0 reply", R_K);

        // Scan load 0xA5, 0x0B (8 + 4 shifts)
        r0 = rise_cnt;
        send(C_S, 3); send(8'hA5, 60); send(8'h0B, 0);
        wait_idle("load1");
        check("load1 rises", rise_cnt - r0, 32'd12);
        expect_tx("load1 reply", R_K);

        // Scan readback
        r0 = rise_cnt;
        send(C_G, 0); wait_idle("read1");
        expect_tx("read1 byte0", 8'hA5);
        expect_tx("read1 byte1", 8'h0B);
        check("read1 rises", rise_cnt - r0, 32'd12);

        // Load 0x3C, 0x05 then read twice
        send(C_S, 3); send(8'h3C, 60); send(8'h05, 0);
        wait_idle("load2");
        expect_tx("load2 reply", R_K);
        send(C_G, 0); wait_idle("read2");
        expect_tx("read2 byte0", 8'h3C);
        expect_tx("read2 byte1", 8'h05);
        send(C_G, 0); wait_idle("read3");
`ifdef SCAN_RECIRC_EN
        expect_tx("read3 byte0", 8'h3C);
        expect_tx("read3 byte1", 8'h05);
`else
        expect_tx("read3 byte0", 8'h00);
        expect_tx("read3 byte1", 8'h00);
`endif

        // Reset during a long run aborts it
        send(C_O, 3); send(8'hFF, 3); send(8'h00, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-run", out_vec(), RST_VEC);
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(C_P, 0); wait_idle("ping3");
        expect_tx("ping3 reply", R_K);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
